resumption_ctx_scheduler: RTL and testbench

- Time-multiplexes one shared single-step resumption device among NUM_REQ independent requesters. The device is a compiled stream machine with a 1-bit input, a 1-bit output, a continue flag and a TAG_W-bit resumption tag.
- The scheduler holds one saved resumption tag per requester. Each arbitration winner gets exactly one device step against its own saved context.
- It sits between the requester ports and the device's combinational step function, which exposes its tag as ports instead of owning the register.

---
 rtl/resumption_ctx_scheduler_if.sv | 29 ++
 rtl/resumption_ctx_scheduler.sv | 129 ++++++++++++
 tb/tb_resumption_ctx_scheduler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/resumption_ctx_scheduler_if.sv
// Requester-side bundle of the resumption context scheduler.
// Handshake: per requester i, a step is accepted in the cycle where
// req_valid[i] && req_ready[i]. req_ready is a one-hot combinational pulse
// that is only raised towards a requester already presenting req_valid, and
// req_data[i] is sampled in that same cycle. rsp_valid is a one-hot, single-cycle
// pulse with no backpressure. rsp_data/rsp_done qualify it.
interface resumption_ctx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               rsp_data;
  logic               rsp_done;
  logic [NUM_REQ-1:0] ctx_clear;

  // Requester side drives requests and clears.
  modport master (
    output req_valid, req_data, ctx_clear,
    input  req_ready, rsp_valid, rsp_data, rsp_done
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_data, ctx_clear,
    output req_ready, rsp_valid, rsp_data, rsp_done
  );
endinterface

// File: rtl/resumption_ctx_scheduler.sv
// Shares one combinational single-step resumption device among NUM_REQ
// requesters. One saved tag per requester. Each grant runs exactly one device
// step against that requester's context (ARB -> STEP -> RESP).
module resumption_ctx_scheduler #(
  parameter int                NUM_REQ  = 4,
  parameter int                TAG_W    = 4,
  parameter logic [TAG_W-1:0]  TAG_INIT = 'h8
) (
  input  logic                        clk,
  input  logic                        rst,
  resumption_ctx_scheduler_if.slave   req_if,
  output logic                        dev_in,
  output logic [TAG_W-1:0]            dev_tag,
  input  logic                        dev_out,
  input  logic                        dev_cont,
  input  logic [TAG_W-1:0]            dev_tag_next,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
  output logic [1:0]                  dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,
    S_STEP = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic               data_bit_q;
  logic               rsp_data_q;
  logic               rsp_done_q;
  logic [TAG_W-1:0]   ctx_q [NUM_REQ];

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  int                 sum;

  // Round-robin search starting just after the last winner, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    sum       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum  = (int'(last_grant_q) + k) % NUM_REQ;
      cand = IDX_W'(sum);
      if (!win_found && req_if.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_ARB;
    else     state_q <= state_d;
  end

  // Next-state logic: one accept, one device step, one response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARB:   if (win_found) state_d = S_STEP;
      S_STEP:  state_d = S_RESP;
      S_RESP:  state_d = S_ARB;
      default: state_d = S_ARB;
    endcase
  end

  // Grant bookkeeping and response capture from the device.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_idx_q  <= '0;
      data_bit_q   <= 1'b0;
      rsp_data_q   <= 1'b0;
      rsp_done_q   <= 1'b0;
    end else begin
      if (state_q == S_ARB && win_found) begin
        grant_idx_q  <= win_idx;
        last_grant_q <= win_idx;
        data_bit_q   <= req_if.req_data[win_idx];
      end
      if (state_q == S_STEP) begin
        rsp_data_q <= dev_out;
        rsp_done_q <= ~dev_cont;
      end
    end
  end

  // Saved contexts: a clear beats the step write-back of the same requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) ctx_q[i] <= TAG_INIT;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_if.ctx_clear[i]) begin
          ctx_q[i] <= TAG_INIT;
        end else if (state_q == S_STEP && grant_idx_q == IDX_W'(i)) begin
          ctx_q[i] <= dev_cont ? dev_tag_next : TAG_INIT;
        end
      end
    end
  end

  // Output decode; req_ready is held low while reset is asserted.
  always_comb begin
    req_if.req_ready = '0;
    req_if.rsp_valid = '0;
    if (state_q == S_ARB && win_found && !rst)
      req_if.req_ready = NUM_REQ'(1) << win_idx;
    if (state_q == S_RESP)
      req_if.rsp_valid = NUM_REQ'(1) << grant_idx_q;
    req_if.rsp_data = rsp_data_q;
    req_if.rsp_done = rsp_done_q;
    dev_in    = (state_q == S_STEP) ? data_bit_q : 1'b0;
    dev_tag   = ctx_q[grant_idx_q];
    busy      = (state_q != S_ARB);
    grant_idx = grant_idx_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_resumption_ctx_scheduler.sv
// Bench for resumption_ctx_scheduler with a tag-incrementing device stub,
// a transaction-level reference model and directed literal checks.
module tb_resumption_ctx_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       dev_in, dev_out, dev_cont;
  logic [3:0] dev_tag, dev_tag_next;
  logic       busy;
  logic [1:0] grant_idx, dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  resumption_ctx_scheduler_if #(.NUM_REQ(4)) req_if ();

  resumption_ctx_scheduler #(.NUM_REQ(4), .TAG_W(4), .TAG_INIT(4'h8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_if       (req_if),
    .dev_in       (dev_in),
    .dev_tag      (dev_tag),
    .dev_out      (dev_out),
    .dev_cont     (dev_cont),
    .dev_tag_next (dev_tag_next),
    .busy         (busy),
    .grant_idx    (grant_idx),
    .dbg_state    (dbg_state)
  );

  // Device stub.
  assign dev_tag_next = dev_tag + 4'd1;
  assign dev_out      = dev_in ^ dev_tag[0];
  assign dev_cont     = (dev_tag != 4'hB);

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_age: cycles since the accept (0 = free to accept, 1 = device cycle,
  // 2 = response cycle).
  int         m_age, m_idx, m_last;
  logic       m_bit, m_rd, m_rdone;
  logic [3:0] m_ctx [4];
  logic [3:0] exp_q [$];   // {idx[1:0], done, data}

  task automatic model_reset();
    m_age = 0; m_idx = 0; m_last = 3; m_bit = 1'b0;
    m_rd = 1'b0; m_rdone = 1'b0;
    for (int i = 0; i < 4; i++) m_ctx[i] = 4'h8;
    exp_q.delete();
  endtask

  always @(negedge clk) begin : compare
    int         win;
    int         c;
    logic [3:0] e;
    logic [3:0] t;
    if (rst) begin
      check("rst_req_ready", req_if.req_ready, 4'h0);
      check("rst_rsp_valid", req_if.rsp_valid, 4'h0);
      check("rst_rsp_data", req_if.rsp_data, 1'b0);
      check("rst_rsp_done", req_if.rsp_done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_grant_idx", grant_idx, 2'd0);
      check("rst_dev_in", dev_in, 1'b0);
      check("rst_dev_tag", dev_tag, 4'h8);
      model_reset();
    end else begin
      win = -1;
      if (m_age == 0) begin
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (win < 0 && req_if.req_valid[c]) win = c;
        end
      end
      check("req_ready", req_if.req_ready, (win >= 0) ? (4'b0001 << win) : 4'b0000);
      check("busy", busy, m_age != 0);
      check("grant_idx", grant_idx, m_idx);
      check("dev_tag", dev_tag, m_ctx[m_idx]);
      check("dev_in", dev_in, (m_age == 1) ? m_bit : 1'b0);
      if (m_age == 2) begin
        if (exp_q.size() == 0) begin
          check("rsp_queue_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          m_rd = e[0];
          m_rdone = e[1];
          check("rsp_valid", req_if.rsp_valid, 4'b0001 << e[3:2]);
        end
      end else begin
        check("rsp_valid_idle", req_if.rsp_valid, 4'h0);
      end
      check("rsp_data", req_if.rsp_data, m_rd);
      check("rsp_done", req_if.rsp_done, m_rdone);
      // Advance the model across the coming clock edge.
      if (m_age == 1) begin
        t = m_ctx[m_idx];
        exp_q.push_back({2'(m_idx), (t == 4'hB), m_bit ^ t[0]});
        m_ctx[m_idx] = (t == 4'hB) ? 4'h8 : t + 4'd1;
      end
      for (int i = 0; i < 4; i++) if (req_if.ctx_clear[i]) m_ctx[i] = 4'h8;
      if (m_age == 0 && win >= 0) begin
        m_idx = win; m_last = win; m_bit = req_if.req_data[win]; m_age = 1;
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age == 2) begin
        m_age = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_all();
    @(posedge clk); #1 req_if.ctx_clear = 4'hF;
    @(posedge clk); #1 req_if.ctx_clear = 4'h0;
  endtask

  task automatic do_step(input int idx, input logic d, input logic clr_in_step,
                         input logic [3:0] pulse_in_resp,
                         output logic [3:0] tag, output logic [3:0] rv,
                         output logic rd, output logic rdn);
    int n;
    logic [3:0] dd;
    @(posedge clk); #1;
    req_if.req_valid = 4'b0001 << idx;
    dd = 4'($urandom);
    dd[idx] = d;
    req_if.req_data = dd;
    n = 0;
    @(negedge clk);
    while (!req_if.req_ready[idx] && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!req_if.req_ready[idx]) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    req_if.req_valid = 4'h0;
    if (clr_in_step) req_if.ctx_clear = 4'b0001 << idx;
    @(negedge clk);
    tag = dev_tag;
    @(posedge clk); #1;
    req_if.ctx_clear = 4'h0;
    req_if.req_valid = pulse_in_resp;
    @(negedge clk);
    rv  = req_if.rsp_valid;
    rd  = req_if.rsp_data;
    rdn = req_if.rsp_done;
    if (pulse_in_resp != 4'h0) begin
      @(posedge clk); #1 req_if.req_valid = 4'h0;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] tag, rv;
  logic       rd, rdn, dbit;
  logic [3:0] seq1 [5]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] t2_tag [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
  logic       t2_rd [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       t2_dn [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] t3_tag [4] = '{4'h8, 4'h8, 4'h9, 4'h9};
  int         t3_req [4] = '{0, 1, 0, 1};

  initial begin
    rst = 1'b1;
    req_if.req_valid = 4'h0;
    req_if.req_data  = 4'h0;
    req_if.ctx_clear = 4'h0;
    repeat (3) @(posedge clk);

    // 1: all requesters valid straight out of reset.
    #1 rst = 1'b0;
    req_if.req_valid = 4'hF;
    req_if.req_data  = 4'($urandom);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i % 3 == 0) check("t1_ready_seq", req_if.req_ready, seq1[i / 3]);
      else            check("t1_ready_gap", req_if.req_ready, 4'h0);
      if (i == 1) check("t1_first_tag", dev_tag, 4'h8);
      if (i == 2) check("t1_first_rsp", req_if.rsp_valid, 4'b0001);
    end
    @(posedge clk); #1 req_if.req_valid = 4'h0;
    repeat (3) @(posedge clk);

    // 2: requester 2 alone through a full session and a restart.
    clear_all();
    for (int k = 0; k < 4; k++) begin
      do_step(2, 1'b1, 1'b0, 4'h0, tag, rv, rd, rdn);
      check("t2_tag", tag, t2_tag[k]);
      check("t2_rsp_valid", rv, 4'b0100);
      check("t2_rsp_data", rd, t2_rd[k]);
      check("t2_rsp_done", rdn, t2_dn[k]);
    end
    do_step(2, 1'b1, 1'b0, 4'h0, tag, rv, rd, rdn);
    check("t2_restart_tag", tag, 4'h8);

    // 3: interleaved requesters keep separate contexts.
    clear_all();
    for (int k = 0; k < 4; k++) begin
      do_step(t3_req[k], 1'($urandom), 1'b0, 4'h0, tag, rv, rd, rdn);
      check("t3_tag", tag, t3_tag[k]);
    end

    // 4: clear collides with the step write-back of the same requester.
    clear_all();
    do_step(1, 1'b0, 1'b0, 4'h0, tag, rv, rd, rdn);
    check("t4_tag_first", tag, 4'h8);
    dbit = 1'b0;
    do_step(1, dbit, 1'b1, 4'h0, tag, rv, rd, rdn);
    check("t4_tag_clr", tag, 4'h9);
    check("t4_rsp_valid", rv, 4'b0010);
    check("t4_rsp_data", rd, 1'b1);
    check("t4_rsp_done", rdn, 1'b0);
    do_step(1, 1'b0, 1'b0, 4'h0, tag, rv, rd, rdn);
    check("t4_tag_after", tag, 4'h8);

    // 5: reset while requester 2 is in its device cycle.
    @(posedge clk); #1 req_if.req_valid = 4'b0100;
    @(negedge clk);
    check("t5_grant2", req_if.req_ready, 4'b0100);
    @(posedge clk); #1 req_if.req_valid = 4'h0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("t5_no_rsp", req_if.rsp_valid, 4'h0);
    @(negedge clk);
    check("t5_no_rsp2", req_if.rsp_valid, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_if.req_valid = 4'hF;
    @(negedge clk);
    check("t5_prio0", req_if.req_ready, 4'b0001);
    @(posedge clk); #1 req_if.req_valid = 4'h0;
    @(negedge clk);
    check("t5_tag0", dev_tag, 4'h8);
    repeat (2) @(posedge clk);
    do_step(1, 1'b0, 1'b0, 4'h0, tag, rv, rd, rdn);
    check("t5_tag1", tag, 4'h8);

    // 6: a one-cycle request during the response phase is not served.
    do_step(0, 1'b1, 1'b0, 4'b0100, tag, rv, rd, rdn);
    check("t6_rsp_valid", rv, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_ready", req_if.req_ready, 4'h0);
      check("t6_idle", busy, 1'b0);
    end

    // Random traffic, clears and occasional resets.
    for (int i = 0; i < 900; i++) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      req_if.req_valid = 4'($urandom_range(0, 15));
      req_if.req_data  = 4'($urandom);
      req_if.ctx_clear = ($urandom_range(0, 31) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'h0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_if.req_valid = 4'h0;
    req_if.ctx_clear = 4'h0;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
